// File: rtl/seg7_display_arbiter_if.sv
// Request/response bundle between display clients and the display arbiter.
interface seg7_display_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]    i_req;
  logic [N_REQ*DW-1:0] i_data;
  logic [N_REQ-1:0]    o_gnt;
  logic [N_REQ-1:0]    o_ack;
  logic                o_cs;
  logic [DW-1:0]       o_data;
  logic [2:0]          o_owner;
  logic                o_busy;

  modport master (
    output i_req, i_data,
    input  o_gnt, o_ack, o_cs, o_data, o_owner, o_busy
  );

  modport slave (
    input  i_req, i_data,
    output o_gnt, o_ack, o_cs, o_data, o_owner, o_busy
  );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between N_REQ
// clients. An owner keeps the display for at least DWELL cycles (counted
// from its grant) before another requester may take it over.
module seg7_display_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 32,
  parameter int DWELL = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_display_arbiter_if.slave bus
);
  localparam int CW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_OPEN} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        rr_ptr, rr_n;
  logic [2:0]        owner, owner_n;
  logic [N_REQ-1:0]  gnt, gnt_n;
  logic [N_REQ-1:0]  ack, ack_n;
  logic              cs, cs_n;
  logic [DW-1:0]     data, data_n;
  logic              busy, busy_n;

  logic [N_REQ-1:0]   pick_mask;
  logic [2*N_REQ-1:0] rot;
  logic               pick_found;
  logic [2:0]         pick_idx;
  logic               owner_req;

  assign owner_req = |(bus.i_req & gnt);

  // Round-robin search: first set bit of pick_mask strictly after rr_ptr.
  // The doubled mask turns the wrap-around into a plain shift.
  always_comb begin
    int off;
    int s;
    pick_mask = '0;
    case (state)
      S_IDLE:  pick_mask = bus.i_req;
      S_OPEN:  pick_mask = bus.i_req & ~gnt;
      default: pick_mask = '0;
    endcase
    rot = {pick_mask, pick_mask} >> (int'(rr_ptr) + 1);
    off = 0;
    pick_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
        pick_found = 1'b1;
      end
    end
    s = int'(rr_ptr) + 1 + off;
    if (s >= N_REQ) s = s - N_REQ;
    pick_idx = 3'(s);
  end

  // Next-state and registered-output logic; a grant restarts the dwell,
  // a refresh rewrites the owner's data without touching the count.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    owner_n = owner;
    gnt_n   = gnt;
    ack_n   = '0;
    cs_n    = 1'b0;
    data_n  = data;
    case (state)
      S_IDLE, S_OPEN: begin
        if (pick_found) begin
          owner_n = pick_idx;
          rr_n    = pick_idx;
          gnt_n   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          ack_n   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          cs_n    = 1'b1;
          data_n  = bus.i_data[int'(pick_idx)*DW +: DW];
          cnt_n   = '0;
          // With a single-cycle dwell the owner is already released.
          state_n = (DWELL == 1) ? S_OPEN : S_DWELL;
        end else if (state == S_OPEN && owner_req) begin
          ack_n  = gnt;
          cs_n   = 1'b1;
          data_n = bus.i_data[int'(owner)*DW +: DW];
        end
      end
      S_DWELL: begin
        cnt_n = cnt + 1'b1;
        // The count stops here, so the OPEN state always sees DWELL-1.
        if (cnt_n == CW'(DWELL - 1)) state_n = S_OPEN;
        if (owner_req) begin
          ack_n  = gnt;
          cs_n   = 1'b1;
          data_n = bus.i_data[int'(owner)*DW +: DW];
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_DWELL);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rr_ptr <= 3'(N_REQ - 1);
      owner  <= '0;
      gnt    <= '0;
      ack    <= '0;
      cs     <= 1'b0;
      data   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_n;
      owner  <= owner_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      cs     <= cs_n;
      data   <= data_n;
      busy   <= busy_n;
    end
  end

  assign bus.o_gnt   = gnt;
  assign bus.o_ack   = ack;
  assign bus.o_cs    = cs;
  assign bus.o_data  = data;
  assign bus.o_owner = owner;
  assign bus.o_busy  = busy;
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench for seg7_display_arbiter with N_REQ=4, DWELL=8.
module tb_seg7_display_arbiter;
  localparam int N_REQ = 4;
  localparam int DW    = 32;
  localparam int DWELL = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  seg7_display_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  seg7_display_arbiter #(.N_REQ(N_REQ), .DW(DW), .DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.i_req = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.i_data = '0;
    do_reset();
    vectors++;
    if ({bus.o_gnt, bus.o_ack, bus.o_cs, bus.o_owner, bus.o_busy} !== 13'd0 || bus.o_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got gnt=%b ack=%b cs=%b data=%h owner=%0d busy=%b want all zero",
               bus.o_gnt, bus.o_ack, bus.o_cs, bus.o_data, bus.o_owner, bus.o_busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.i_req = 4'b0100;
    bus.i_data[2*DW +: DW] = 32'h0000_00C2;
    step();
    vectors++;
    if ({bus.o_cs, bus.o_ack, bus.o_gnt, bus.o_busy, bus.o_owner} !== {1'b1, 4'b0100, 4'b0100, 1'b1, 3'd2}
        || bus.o_data !== 32'hC2) begin
      miscompares++;
      $display("FAIL single_write got cs=%b data=%h ack=%b gnt=%b busy=%b owner=%0d want 1 c2 0100 0100 1 2",
               bus.o_cs, bus.o_data, bus.o_ack, bus.o_gnt, bus.o_busy, bus.o_owner);
    end
    bus.i_req = '0;
    step();
    vectors++;
    if (bus.o_cs !== 1'b0 || bus.o_ack !== 4'b0 || bus.o_gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_release got cs=%b ack=%b gnt=%b want 0 0000 0100", bus.o_cs, bus.o_ack, bus.o_gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    do_reset();
    for (int k = 0; k < N_REQ; k++) bus.i_data[k*DW +: DW] = 32'hA0 + k;
    bus.i_req = 4'b1111;
    step();
    vectors++;
    if (bus.o_gnt !== 4'b0001 || bus.o_ack !== 4'b0001 || bus.o_data !== 32'hA0) begin
      miscompares++;
      $display("FAIL rr_first got gnt=%b ack=%b data=%h want 0001 0001 a0", bus.o_gnt, bus.o_ack, bus.o_data);
    end
    for (int g = 1; g <= 4; g++) begin
      oh = 4'b0001 << ((g - 1) % 4);
      for (int c = 1; c <= 7; c++) begin
        step();
        vectors++;
        if (bus.o_gnt !== oh || bus.o_ack !== oh || bus.o_busy !== (c <= 6)) begin
          miscompares++;
          $display("FAIL rr_hold g=%0d c=%0d got gnt=%b ack=%b busy=%b want %b %b %b",
                   g, c, bus.o_gnt, bus.o_ack, bus.o_busy, oh, oh, (c <= 6));
        end
      end
      oh = 4'b0001 << (g % 4);
      step();
      vectors++;
      if (bus.o_gnt !== oh || bus.o_ack !== oh || bus.o_data !== 32'hA0 + (g % 4) || bus.o_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_switch g=%0d got gnt=%b ack=%b data=%h busy=%b want %b %b %h 1",
                 g, bus.o_gnt, bus.o_ack, bus.o_data, bus.o_busy, oh, oh, 32'hA0 + (g % 4));
      end
    end
  endtask

  task automatic test_refresh();
    do_reset();
    bus.i_req = 4'b0010;
    bus.i_data[1*DW +: DW] = 32'h100;
    step();
    for (int c = 1; c <= 10; c++) begin
      bus.i_data[1*DW +: DW] = 32'h100 + c;
      step();
      vectors++;
      if (bus.o_cs !== 1'b1 || bus.o_data !== 32'h100 + c || bus.o_ack !== 4'b0010 || bus.o_busy !== (c <= 6)) begin
        miscompares++;
        $display("FAIL refresh c=%0d got cs=%b data=%h ack=%b busy=%b want 1 %h 0010 %b",
                 c, bus.o_cs, bus.o_data, bus.o_ack, bus.o_busy, 32'h100 + c, (c <= 6));
      end
    end
  endtask

  task automatic test_open_contention();
    do_reset();
    bus.i_req = 4'b0001;
    bus.i_data[0*DW +: DW] = 32'h10;
    bus.i_data[3*DW +: DW] = 32'h33;
    step();
    for (int c = 1; c <= 7; c++) step();
    vectors++;
    if (bus.o_busy !== 1'b0 || bus.o_gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL open_state got busy=%b gnt=%b want 0 0001", bus.o_busy, bus.o_gnt);
    end
    bus.i_req = 4'b1001;
    step();
    vectors++;
    if (bus.o_gnt !== 4'b1000 || bus.o_ack !== 4'b1000 || bus.o_data !== 32'h33 || bus.o_owner !== 3'd3) begin
      miscompares++;
      $display("FAIL open_takeover got gnt=%b ack=%b data=%h owner=%0d want 1000 1000 33 3",
               bus.o_gnt, bus.o_ack, bus.o_data, bus.o_owner);
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.i_req = 4'b0001;
    step();
    bus.i_req = 4'b0101;
    step();
    bus.i_req = 4'b0001;
    vectors++;
    if (bus.o_ack !== 4'b0001 || bus.o_gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL drop_pulse got ack=%b gnt=%b want 0001 0001", bus.o_ack, bus.o_gnt);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (bus.o_gnt !== 4'b0001 || bus.o_ack[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_hold c=%0d got gnt=%b ack=%b want 0001 with ack[2]=0", c, bus.o_gnt, bus.o_ack);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.i_req = 4'b0001;
    step();
    for (int c = 0; c < 4; c++) step();
    reset = 1'b0;
    bus.i_req = 4'b0110;
    step();
    reset = 1'b1;
    vectors++;
    if ({bus.o_gnt, bus.o_ack, bus.o_cs, bus.o_owner, bus.o_busy} !== 13'd0 || bus.o_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid got gnt=%b ack=%b cs=%b data=%h owner=%0d busy=%b want all zero",
               bus.o_gnt, bus.o_ack, bus.o_cs, bus.o_data, bus.o_owner, bus.o_busy);
    end
    step();
    vectors++;
    if (bus.o_gnt !== 4'b0010 || bus.o_ack !== 4'b0010 || bus.o_owner !== 3'd1) begin
      miscompares++;
      $display("FAIL reset_regrant got gnt=%b ack=%b owner=%0d want 0010 0010 1", bus.o_gnt, bus.o_ack, bus.o_owner);
    end
  endtask

  initial begin
    bus.i_req = '0;
    bus.i_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_refresh();
    test_open_contention();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
